// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fir_pkg                                                      |
// | Description : Shared constants, sample type and saturation helpers for     |
// |               the FIR output path.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fir_pkg;

  // Default accumulator and output sample widths.
  localparam int c_n3    = 32;
  localparam int c_out_w = 16;

  // Signed output sample at the default width.
  typedef logic signed [c_out_w-1:0] sample_t;

  // Largest and smallest two's-complement values of a w-bit signed number,
  // returned at 64 bits so callers can size them to their own datapath.
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Saturation limits at the default output width.
  localparam sample_t c_sat_max = sample_t'(sat_hi(c_out_w));
  localparam sample_t c_sat_min = sample_t'(sat_lo(c_out_w));

endpackage
`default_nettype wire

// File: rtl/fir_out_quantizer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : fir_out_quantizer_if                                         |
// | Description : Sample strobe from the filter and valid/ready stream to the  |
// |               sink, bundled for the output quantizer.                      |
// |   in_valid  : one-cycle strobe per filtered sample                         |
// |   in_data   : signed accumulator sample (N3 bits)                          |
// |   out_valid : head-of-FIFO sample available                                |
// |   out_ready : sink accepts out_data this cycle                             |
// |   out_data  : signed output sample (OUT_W bits)                            |
// |   master    : filter/sink side; slave : quantizer side                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fir_out_quantizer_if
  import fir_pkg::*;
#(
  parameter int N3    = c_n3,
  parameter int OUT_W = c_out_w
);
  logic                    in_valid;
  logic signed [N3-1:0]    in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_sync_fifo                                                |
// | Description : Single-clock FIFO, DEPTH entries (power of two, >= 2).       |
// |               Read data is the word at the read pointer (no bypass), so a  |
// |               write into an empty FIFO becomes visible the next cycle.     |
// |               A write while full is accepted only if a read happens in     |
// |               the same cycle.                                              |
// |   clk, rst  : clock, asynchronous active-high reset (clears memory too)    |
// |   wr_en     : write request;  wr_data : write word                         |
// |   rd_en     : read request (ignored when empty)                            |
// |   rd_data   : head word;  full / empty : occupancy flags                   |
// |   wr_accept : the write request was taken this cycle                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  wire          clk,
  input  wire          rst,
  input  wire          wr_en,
  input  wire  [W-1:0] wr_data,
  input  wire          rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         wr_accept
);
  localparam int c_aw = $clog2(DEPTH);

  // Pointers carry one extra bit: equal low bits with differing top bits
  // means full, fully equal means empty.
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_do_rd;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_rd   = rd_en & ~empty;
  // When full, the slot being written is the one being read this cycle;
  // the read sees the old word before the edge, so both may proceed.
  assign wr_accept = wr_en & (~full | w_do_rd);
  assign rd_data   = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (wr_accept) begin
        r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fir_out_quantizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_out_quantizer                                            |
// | Description : FIR output stage. Decimates the accumulator stream by DECIM, |
// |               rounds half-up, shifts right by SHIFT, reduces to OUT_W bits |
// |               and queues results in a DEPTH-entry FIFO toward the sink.    |
// |               The filter is never stalled: a result that finds the FIFO    |
// |               full (with no read that cycle) is dropped and overrun set.   |
// |   clk, rst  : clock, asynchronous active-high reset                        |
// |   bus       : fir_out_quantizer_if.slave (in_valid/in_data from filter,    |
// |               out_valid/out_ready/out_data to sink)                        |
// |   overrun   : sticky, a kept sample was dropped                            |
// |   sat_cnt   : saturating count of clipped samples (holds at 255)           |
// | Build macro : FIR_OUTQ_SAT_EN - defined: clip to OUT_W range and count;    |
// |               undefined: keep low OUT_W bits (wrap), sat_cnt tied to 0.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_out_quantizer
  import fir_pkg::*;
#(
  parameter int N3    = c_n3,
  parameter int OUT_W = c_out_w,
  parameter int SHIFT = 8,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  wire               clk,
  input  wire               rst,
  fir_out_quantizer_if.slave bus,
  output logic              overrun,
  output logic [7:0]        sat_cnt
);
  // Rounding is done one bit wider than the input so the half-LSB add
  // cannot overflow.
  localparam int c_r_w  = N3 + 1;
  localparam int c_ph_w = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [c_r_w-1:0] c_half = c_r_w'(64'd1 << (SHIFT - 1));

  logic [c_ph_w-1:0]        r_ph;
  logic                     w_keep;
  logic signed [c_r_w-1:0]  w_sum;
  logic signed [c_r_w-1:0]  w_r;
  logic [OUT_W-1:0]         w_red;
  logic [OUT_W-1:0]         r_q;
  logic                     r_q_v;
  logic                     r_overrun;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_wr_accept;
  logic [OUT_W-1:0]         w_rd_data;

  // ---------------------------------------------------------------- decimation
  assign w_keep = bus.in_valid && (r_ph == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph <= '0;
    end else if (bus.in_valid) begin
      r_ph <= (r_ph == c_ph_w'(DECIM - 1)) ? '0 : r_ph + 1'b1;
    end
  end

  // ------------------------------------------------------------ round + shift
  assign w_sum = $signed({bus.in_data[N3-1], bus.in_data}) + c_half;
  assign w_r   = w_sum >>> SHIFT;

  // ---------------------------------------------------------- range reduction
`ifdef FIR_OUTQ_SAT_EN
  localparam logic signed [c_r_w-1:0] c_hi = c_r_w'(sat_hi(OUT_W));
  localparam logic signed [c_r_w-1:0] c_lo = c_r_w'(sat_lo(OUT_W));

  logic       w_clip_hi;
  logic       w_clip_lo;
  logic [7:0] r_sat_cnt;

  assign w_clip_hi = (w_r > c_hi);
  assign w_clip_lo = (w_r < c_lo);
  assign w_red     = w_clip_hi ? c_hi[OUT_W-1:0] :
                     w_clip_lo ? c_lo[OUT_W-1:0] : w_r[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (w_keep && (w_clip_hi || w_clip_lo) && (r_sat_cnt != 8'hFF)) begin
      r_sat_cnt <= r_sat_cnt + 8'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  // Two's-complement wrap: the bits above OUT_W are intentionally discarded.
  logic w_unused_r_hi;
  assign w_unused_r_hi = ^w_r[c_r_w-1:OUT_W];
  assign w_red         = w_r[OUT_W-1:0];
  assign sat_cnt       = 8'd0;
`endif

  // ----------------------------------------------------------- stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_q_v <= 1'b0;
    end else begin
      r_q_v <= w_keep;
      if (w_keep) begin
        r_q <= w_red;
      end
    end
  end

  // -------------------------------------------------------------- output FIFO
  fir_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (r_q_v),
    .wr_data   (r_q),
    .rd_en     (bus.out_ready),
    .rd_data   (w_rd_data),
    .full      (w_full),
    .empty     (w_empty),
    .wr_accept (w_wr_accept)
  );

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_rd_data;

  // A pending result that the FIFO refused is a lost sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (r_q_v && !w_wr_accept) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;

  logic w_unused_full;
  assign w_unused_full = w_full;
endmodule
`default_nettype wire

// File: tb/tb_fir_out_quantizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_out_quantizer                                         |
// | Description : Self-checking bench for fir_out_quantizer. Two instances:    |
// |               dut1 (DECIM=1) and dut4 (DECIM=4). Expected samples are      |
// |               queued when driven and compared when the sink accepts them.  |
// |               Honours FIR_OUTQ_SAT_EN for saturating vs wrapping results.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_out_quantizer;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_out_quantizer_if #(.N3(32), .OUT_W(16)) bus1 ();
  fir_out_quantizer_if #(.N3(32), .OUT_W(16)) bus4 ();

  logic       ovr1, ovr4;
  logic [7:0] sat1, sat4;

  fir_out_quantizer #(.N3(32), .OUT_W(16), .SHIFT(8), .DECIM(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .overrun(ovr1), .sat_cnt(sat1));

  fir_out_quantizer #(.N3(32), .OUT_W(16), .SHIFT(8), .DECIM(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .overrun(ovr4), .sat_cnt(sat4));

  int checks = 0;
  int errors = 0;
  int n_out4 = 0;
  logic [15:0] q1[$];
  logic [15:0] q4[$];

  typedef struct {
    logic [31:0] din;
    sample_t     exp_sat;
    sample_t     exp_wrap;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: compare at the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected output: got 0x%0h expected none", bus1.out_data);
      end else begin
        check("dut1 out_data", {16'h0, bus1.out_data}, {16'h0, q1.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      n_out4++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4 unexpected output: got 0x%0h expected none", bus4.out_data);
      end else begin
        check("dut4 out_data", {16'h0, bus4.out_data}, {16'h0, q4.pop_front()});
      end
    end
  end

  function automatic logic [15:0] pick(input vec_t v);
`ifdef FIR_OUTQ_SAT_EN
    return v.exp_sat;
`else
    return v.exp_wrap;
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    q1.delete();
    q4.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Drive n samples k*256 for k = first..first+n-1 back to back on dut1.
  task automatic burst1(input int first, input int n, input int n_expect);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 bus1.in_valid = 1'b1;
      bus1.in_data = 32'(first + k) << 8;
      if (k < n_expect) q1.push_back(16'(first + k));
    end
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0001_2380, 16'h0124, 16'h0124};
    vecs[1]  = '{32'hFFFF_FE80, 16'hFFFF, 16'hFFFF};  // -384
    vecs[2]  = '{32'h0100_0000, 16'h7FFF, 16'h0000};  // clip high
    vecs[3]  = '{32'h8000_0000, 16'h8000, 16'h0000};  // clip low
    vecs[4]  = '{32'h0000_0000, 16'h0000, 16'h0000};
    vecs[5]  = '{32'h0000_007F, 16'h0000, 16'h0000};  // just below half
    vecs[6]  = '{32'h0000_0080, 16'h0001, 16'h0001};  // exact half rounds up
    vecs[7]  = '{32'hFFFF_FF7F, 16'hFFFF, 16'hFFFF};  // -129
    vecs[8]  = '{32'hFFFF_FF80, 16'h0000, 16'h0000};  // -128 rounds up to 0
    vecs[9]  = '{32'h007F_FF7F, 16'h7FFF, 16'h7FFF};  // max, no clip
    vecs[10] = '{32'h007F_FF80, 16'h7FFF, 16'h8000};  // one past max
    vecs[11] = '{32'hFF80_0000, 16'h8000, 16'h8000};  // min, no clip
    vecs[12] = '{32'hFF7F_FF7F, 16'h8000, 16'h7FFF};  // one past min

    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset out_valid", {31'h0, bus1.out_valid}, 32'h0);
    check("reset out_data",  {16'h0, bus1.out_data}, 32'h0);
    check("reset overrun",   {31'h0, ovr1}, 32'h0);
    check("reset sat_cnt",   {24'h0, sat1}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // First-sample latency: capture edge k, visible after edge k+1.
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b1; bus1.in_data = 32'h0001_2380;
    q1.push_back(16'h0124);
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    check("latency edge k out_valid", {31'h0, bus1.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("latency edge k+1 out_valid", {31'h0, bus1.out_valid}, 32'h1);
    check("latency edge k+1 out_data", {16'h0, bus1.out_data}, 32'h0124);
    repeat (3) @(posedge clk);

    // Vector table, one sample per cycle.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1 bus1.in_valid = 1'b1;
      bus1.in_data = vecs[i].din;
      q1.push_back(pick(vecs[i]));
    end
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("table drained", 32'(q1.size()), 32'h0);
    check("table out_valid low", {31'h0, bus1.out_valid}, 32'h0);
    check("table no overrun", {31'h0, ovr1}, 32'h0);
`ifdef FIR_OUTQ_SAT_EN
    check("table sat_cnt", {24'h0, sat1}, 32'd4);
`else
    check("table sat_cnt", {24'h0, sat1}, 32'd0);
`endif

    // Decimation by 4 with idle gaps between strobes.
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1 bus4.in_valid = 1'b1;
      bus4.in_data = 32'(n) << 8;
      if (n == 1 || n == 5) q4.push_back(16'(n));
      @(posedge clk);
      #1 bus4.in_valid = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    check("decim output count", 32'(n_out4), 32'd2);
    check("decim drained", 32'(q4.size()), 32'h0);

    // Overrun: five kept samples into a 4-deep FIFO with the sink stalled.
    do_reset();
    bus1.out_ready = 1'b0;
    burst1(1, 5, 4);
    repeat (3) @(posedge clk);
    #1;
    check("overrun out_valid", {31'h0, bus1.out_valid}, 32'h1);
    check("overrun flag", {31'h0, ovr1}, 32'h1);
    check("overrun head", {16'h0, bus1.out_data}, 32'h0001);
    repeat (2) @(posedge clk);
    #1;
    check("stall head stable", {16'h0, bus1.out_data}, 32'h0001);
    check("stall valid stable", {31'h0, bus1.out_valid}, 32'h1);
    bus1.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("overrun drained", 32'(q1.size()), 32'h0);
    check("overrun out_valid low", {31'h0, bus1.out_valid}, 32'h0);
    check("overrun sticky", {31'h0, ovr1}, 32'h1);

    // Full FIFO with read and write on the same edge.
    do_reset();
    bus1.out_ready = 1'b0;
    burst1(10, 4, 4);
    repeat (2) @(posedge clk);
    #1 bus1.in_valid = 1'b1; bus1.in_data = 32'(14) << 8;
    q1.push_back(16'd14);
    @(posedge clk);
    #1 bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("full r/w no overrun", {31'h0, ovr1}, 32'h0);
    check("full r/w drained", 32'(q1.size()), 32'h0);

    // Asynchronous reset with three entries queued.
    do_reset();
    bus1.out_ready = 1'b0;
    burst1(20, 3, 3);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset out_valid", {31'h0, bus1.out_valid}, 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    q1.delete();
    #1;
    check("async reset out_valid", {31'h0, bus1.out_valid}, 32'h0);
    check("async reset out_data", {16'h0, bus1.out_data}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b1; bus1.in_data = 32'(30) << 8;
    q1.push_back(16'd30);
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    check("post-reset edge k out_valid", {31'h0, bus1.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("post-reset edge k+1 out_valid", {31'h0, bus1.out_valid}, 32'h1);
    check("post-reset edge k+1 out_data", {16'h0, bus1.out_data}, 32'd30);
    repeat (4) @(posedge clk);
    #1;
    check("post-reset drained", 32'(q1.size()), 32'h0);
    check("post-reset no overrun", {31'h0, ovr1}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fir_out_quantizer.md
# fir_out_quantizer

- Downstream stage of the FIR filter.
- Takes the signed full-width accumulator sample, decimates it by a fixed ratio, then rounds, scales and saturates it to the output sample width.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the sink (DAC formatter or capture logic).
- Absorbs sink stalls without back-pressuring the filter; losses are flagged, never silent.

## Interface
Parameters:
- N3, 32: input (accumulator) width, signed
- OUT_W, 16: output sample width, signed
- SHIFT, 8: arithmetic right-shift applied after rounding; 1 ≤ SHIFT < N3
- DECIM, 4: decimation ratio; 1 keeps every sample
- DEPTH, 4: FIFO entries, power of two, ≥ 2

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high; clears all state
- in_valid  in  1  one-cycle strobe, one per filtered sample
- in_data  in  N3  signed filter output, sampled when in_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts out_data this cycle
- out_data  out  OUT_W  signed head-of-FIFO sample
- overrun  out  1  sticky: a kept sample was dropped because the FIFO was full
- sat_cnt  out  8  saturating count of clipped samples

## Operation
- Decimation phase counter `ph`, range 0..DECIM-1:
  - advances on every in_valid and wraps to 0 after DECIM-1.
  - A sample is kept only when in_valid=1 and ph=0, so the first sample after reset is kept.
  - in_valid=0 leaves ph unchanged.
- Rounding of a kept sample:
  - Computed at N3+1 bits: r = (in_data + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up.
  - The extra bit prevents overflow of the addition.
- Range reduction to OUT_W bits:
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; see Configuration.
  - Each clipped sample increments sat_cnt, which holds at 255.
- Stage register `q`, `q_v`: loaded with the reduced value on a kept sample; q_v=0 otherwise.
- FIFO write when q_v=1:
  - FIFO not full: write q.
  - FIFO full and out_ready=0: drop q, set overrun.
  - FIFO full and out_ready=1 in the same cycle: both the read and the write occur; nothing is dropped.
- FIFO read when out_valid & out_ready. out_data is the memory word at rd_ptr.
- Pointers are log2(DEPTH)+1 bits wide. The extra bit tells full from empty; the low bits wrap.
- Empty FIFO with a simultaneous write: no bypass. out_valid rises the following cycle.
- overrun clears only on rst.

## Timing
- Reset values:
  - out_valid=0, overrun=0, sat_cnt=0
  - out_data=0 (memory cleared)
  - ph=0, q_v=0, pointers 0
- Reset asserted mid-operation: all stored and in-flight samples are discarded immediately; no partial output.
- Latency:
  - A kept sample captured at rising edge k is in q after edge k and is written to the FIFO at edge k+1.
  - out_valid=1 with that data after edge k+1, i.e. 2 edges from capture when the FIFO was empty.
- Throughput: one sample per cycle (DECIM=1, out_ready=1) with no drops.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.

## Configuration
- FIR_OUTQ_SAT_EN:
  - Defined: saturation as described; sat_cnt active.
  - Undefined: the low OUT_W bits of r are taken (two's-complement wrap), no clipping logic is built, and sat_cnt is tied to 0.

## Structure
- Shared package `fir_pkg` holds:
  - sample/accumulator width constants
  - the signed output sample typedef
  - the saturation min/max constants
- Sub-module `fir_sync_fifo`:
  - parameterised DEPTH and width
  - outputs full/empty
  - asynchronous active-high reset on clk/rst

## Test plan
- Rounding, macro defined, DECIM=1, out_ready=1:
  - in_data 0x00012380 → out_data 0x0124
  - in_data -384 → out_data 0xFFFF (-1)
- Saturation:
  - 0x01000000 → 0x7FFF and 0x80000000 → 0x8000, sat_cnt=2.
  - Without macro: both give 0x0000 and sat_cnt=0.
- Decimation, DECIM=4: eight in_valid pulses with in_data = n·256, n=1..8 → exactly two outputs, 0x0001 then 0x0005.
- Overrun, DECIM=1, DEPTH=4, out_ready=0, five kept samples 1..5 (·256):
  - out_valid stays high and overrun=1 after the fifth.
  - Raising out_ready then drains 1,2,3,4 and out_valid drops.
- Full with simultaneous read and write: FIFO full, out_ready=1 on the same cycle as a write → no drop, overrun stays 0, order preserved.
- Mid-stream reset: assert rst asynchronously with 3 entries queued → out_valid=0 before the next edge; the next kept sample appears 2 edges after capture.
